// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with fetch-side control: hazard hold, instruction-memory
// stall handling, branch flush with late-data drop, and HALT freeze.
module if_id_pipe #(
  parameter logic [15:0] NOP_INST = 16'h0800,
  parameter logic [4:0]  HALT_OP  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic [15:0] pc2_in,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic        sendNOP,
  input  logic        flush,
  output logic [15:0] inst_out,
  output logic [15:0] pc2_out,
  output logic        valid_out,
  output logic        pc_wr_en,
  output logic        halted,
  output logic [7:0]  stall_cnt
);

  // state    | meaning
  // RUN      | normal fetch; decode register advances every cycle
  // HAZ_HOLD | decode hazard; IF/ID contents frozen, PC held
  // MEM_WAIT | imem busy; bubbles into decode until imem_done
  // HALTED   | HALT latched; fetch frozen until a flush
  typedef enum logic [1:0] {RUN, HAZ_HOLD, MEM_WAIT, HALTED} state_t;

  state_t      state, state_nxt;
  logic        drop, drop_nxt;
  logic [15:0] inst_nxt, pc2_nxt;
  logic        valid_nxt;
  logic        take;
  logic        we;
  logic        is_halt;

  assign is_halt = (inst_in[15:11] == HALT_OP);

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    inst_nxt  = inst_out;
    pc2_nxt   = pc2_out;
    valid_nxt = valid_out;
    take      = 1'b0;
    we        = 1'b0;
    if (flush) begin
      inst_nxt  = NOP_INST;
      pc2_nxt   = 16'h0000;
      valid_nxt = 1'b0;
      we        = 1'b1;
      state_nxt = imem_stall ? MEM_WAIT : RUN;
      drop_nxt  = imem_stall;
    end else begin
      case (state)
        RUN, HAZ_HOLD: begin
          // A hazard already holding decode outranks a new imem stall.
          if (state == HAZ_HOLD && !sendNOP) begin
            state_nxt = HAZ_HOLD;
          end else if (imem_stall) begin
            state_nxt = MEM_WAIT;
            inst_nxt  = NOP_INST;
            valid_nxt = 1'b0;
          end else if (!sendNOP) begin
            state_nxt = HAZ_HOLD;
          end else begin
            take = 1'b1;
          end
        end
        MEM_WAIT: begin
          inst_nxt  = NOP_INST;
          valid_nxt = 1'b0;
          if (imem_done) begin
            drop_nxt  = 1'b0;
            state_nxt = RUN;
            take      = !drop;
          end
        end
        HALTED: begin
          inst_nxt  = NOP_INST;
          valid_nxt = 1'b0;
        end
        default: state_nxt = RUN;
      endcase
    end
    if (take) begin
      inst_nxt  = inst_in;
      pc2_nxt   = pc2_in;
      valid_nxt = 1'b1;
      we        = 1'b1;
      state_nxt = is_halt ? HALTED : RUN;
    end
  end

  // Gated by reset so the PC cannot be written while the pipe is held in reset.
  assign pc_wr_en = we & rst;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drop      <= 1'b0;
      inst_out  <= NOP_INST;
      pc2_out   <= 16'h0000;
      valid_out <= 1'b0;
      stall_cnt <= 8'h00;
    end else begin
      state     <= state_nxt;
      drop      <= drop_nxt;
      inst_out  <= inst_nxt;
      pc2_out   <= pc2_nxt;
      valid_out <= valid_nxt;
      if (!pc_wr_en && state != HALTED && stall_cnt != 8'hFF)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 SHALL have parameter NOP_INST, default 16'h0800, the bubble instruction written into decode.
REQ-002 SHALL have parameter HALT_OP, default 5'b00000, the opcode (inst[15:11]) that halts fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inst_in  input  16  fetched instruction from instruction memory.
REQ-006 SHALL have port pc2_in  input  16  PC+2 of the fetched instruction.
REQ-007 SHALL have port imem_stall  input  1  high while the instruction memory has no data this cycle.
REQ-008 SHALL have port imem_done  input  1  one-cycle pulse: inst_in is valid after a stall.
REQ-009 SHALL have port sendNOP  input  1  from the decode hazard unit; low = hold decode.
REQ-010 SHALL have port flush  input  1  taken branch/jump resolved; squash fetch/decode.
REQ-011 SHALL have port inst_out  output  16  registered instruction presented to decode.
REQ-012 SHALL have port pc2_out  output  16  registered PC+2 matching inst_out.
REQ-013 SHALL have port valid_out  output  1  inst_out is a real instruction, not a bubble.
REQ-014 SHALL have port pc_wr_en  output  1  combinational PC-register write enable.
REQ-015 SHALL have port halted  output  1  fetch frozen after HALT.
REQ-016 SHALL have port stall_cnt  output  8  saturating count of stalled cycles.

Function
REQ-017 SHALL implement the states RUN, HAZ_HOLD, MEM_WAIT and HALTED, encoded in registers.
REQ-018 SHALL give events in each cycle the priority flush > imem_stall > hazard (sendNOP==0) > normal advance.
REQ-019 SHALL, in RUN with no event, load inst_out<=inst_in, pc2_out<=pc2_in and valid_out<=1, drive pc_wr_en=1, and stay in RUN.
REQ-020 SHALL, in RUN when inst_in[15:11]==HALT_OP and no event, latch the HALT as in REQ-019, drive pc_wr_en=1 that cycle, and go to HALTED.
REQ-021 SHALL, on sendNOP==0 in RUN or HAZ_HOLD, hold inst_out, pc2_out and valid_out, drive pc_wr_en=0, and go to (or stay in) HAZ_HOLD.
REQ-022 SHALL, in HAZ_HOLD when sendNOP returns high, act as REQ-019 in that same cycle and go to RUN.
REQ-023 SHALL, on imem_stall in RUN or HAZ_HOLD, go to MEM_WAIT, drive pc_wr_en=0, and load inst_out<=NOP_INST, valid_out<=0.
REQ-024 SHALL exempt from REQ-023 the case sendNOP==0 in HAZ_HOLD: that case holds per REQ-021 and stays in HAZ_HOLD.
REQ-025 SHALL, in MEM_WAIT, load NOP_INST every cycle and drive pc_wr_en=0 until imem_done.
REQ-026 SHALL, on imem_done in MEM_WAIT, latch inst_in per REQ-019/020 and leave MEM_WAIT.
REQ-027 SHALL, on flush in any state, load inst_out<=NOP_INST, valid_out<=0, pc2_out<=0 and drive pc_wr_en=1.
REQ-028 SHALL, on flush, go to MEM_WAIT with drop=1 if imem_stall is high, else go to RUN.
REQ-029 SHALL, when imem_done arrives with drop=1, discard inst_in, load NOP_INST, clear drop, and go to RUN.
REQ-030 SHALL clear drop whenever any flush-free cycle leaves MEM_WAIT.
REQ-031 SHALL, in HALTED, load NOP_INST every cycle, drive pc_wr_en=0, drive halted=1, and ignore imem_stall and sendNOP.
REQ-032 SHALL, on flush in HALTED (wrong-path HALT), drop halted and return per REQ-028.
REQ-033 SHALL increment stall_cnt each cycle pc_wr_en==0 and state!=HALTED, saturating at 8'hFF with no wrap.
REQ-034 SHALL drive pc_wr_en combinationally from the current state and inputs, with no registered delay.

Reset
REQ-035 SHALL, while rst==0, force inst_out=NOP_INST, pc2_out=16'h0000, valid_out=0, halted=0, stall_cnt=0, drop=0, state=RUN and pc_wr_en=0, immediately (asynchronously).
REQ-036 SHALL, on the first rising clk after rst deasserts, behave as RUN with no carried-over state.
REQ-037 SHALL, if reset is asserted mid-MEM_WAIT or mid-HALTED, abandon that state, with no pending drop or halt surviving reset.

Verification
REQ-038 SHALL verify normal advance: inst_in=16'hD8A0, pc2_in=16'h0004, all events low -> next edge inst_out=D8A0, pc2_out=0004, valid_out=1, pc_wr_en=1.
REQ-039 SHALL verify hazard hold: sendNOP=0 for 3 cycles -> inst_out held, pc_wr_en=0, stall_cnt +3, then resume on the sendNOP rise edge.
REQ-040 SHALL verify the memory stall: imem_stall high 4 cycles, then imem_done with inst_in=16'h4123 -> 4 NOP_INST cycles, then inst_out=4123, valid_out=1.
REQ-041 SHALL verify flush during a stall: flush while imem_stall=1, then imem_done with 16'hC0FF -> C0FF is never seen on inst_out, NOP_INST is loaded, state=RUN.
REQ-042 SHALL verify halt and wrong-path recovery: inst_in=16'h0000 -> halted=1 on the next edge, pc_wr_en=0, inst_out=NOP_INST thereafter; a later flush -> halted=0, pc_wr_en=1.
REQ-043 SHALL verify saturation and async reset: hold sendNOP=0 for 300 cycles -> stall_cnt=8'hFF; assert rst mid-clock -> all outputs at reset values without waiting for an edge.
